fetch_gshare_stage: RTL and testbench

Fetch stage feeding the fetch/decode pipeline register. It holds the program counter and drives the instruction-memory address. It predicts conditional branches with a 3-bit gshare predictor: an 8-entry pattern history table (PHT) of 2-bit counters, indexed by PC[2:0] XOR a 3-bit global history register (GHR). It presents Finstruction, Finstruction_increment, Fpc and xorout to the decode pipeline register, and accepts branch resolution and redirect from execute.

---
 rtl/fetch_gshare_stage.sv | 94 +++++++++
 tb/tb_fetch_gshare_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_gshare_stage.sv
// Fetch stage: holds the PC, drives instruction memory, predicts branches with a
// 3-bit gshare predictor and redirects on execute-stage mispredicts.
module fetch_gshare_stage #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter logic [5:0]  BRANCH_OPCODE = 6'b010000,
    parameter logic [5:0]  JUMP_OPCODE   = 6'b010001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Dstall,
    output logic [15:0] imem_addr,
    input  logic [17:0] imem_data,
    output logic [17:0] Finstruction,
    output logic [15:0] Finstruction_increment,
    output logic [15:0] Fpc,
    output logic [2:0]  xorout,
    output logic        Fpredict_taken,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic [2:0]  resolve_index,
    input  logic        resolve_mispredict,
    input  logic [15:0] resolve_target,
    output logic        flush_FD
);

    logic [15:0] r_pc;
    logic [2:0]  r_ghr;
    logic [1:0]  r_pht [0:7];

    logic [5:0]  w_opcode;
    logic [15:0] w_target;
    logic [15:0] w_pc_inc;
    logic [2:0]  w_index;
    logic        w_predict;
    logic [15:0] w_next_pc;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        if (taken) begin
            result = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            result = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return result;
    endfunction

    assign w_opcode  = imem_data[17:12];
    assign w_target  = {r_pc[15:12], imem_data[11:0]};
    assign w_pc_inc  = r_pc + 16'd1;
    assign w_index   = r_pc[2:0] ^ r_ghr;
    assign w_predict = (w_opcode == JUMP_OPCODE) |
                       ((w_opcode == BRANCH_OPCODE) & r_pht[w_index][1]);

    assign imem_addr              = r_pc;
    assign Finstruction           = imem_data;
    assign Finstruction_increment = w_pc_inc;
    assign Fpc                    = r_pc;
    assign xorout                 = w_index;
    assign Fpredict_taken         = w_predict;
    assign flush_FD               = resolve_mispredict;

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        w_next_pc = w_pc_inc;
        if (resolve_mispredict) begin
            w_next_pc = resolve_target;
        end else if (Dstall) begin
            w_next_pc = r_pc;
        end else if (w_predict) begin
            w_next_pc = w_target;
        end else begin
            w_next_pc = w_pc_inc;
        end
    end

    // PC, history and pattern table; history only moves at resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_ghr <= 3'b000;
            for (int i = 0; i < 8; i++) begin
                r_pht[i] <= 2'b01;
            end
        end else begin
            r_pc <= w_next_pc;
            if (resolve_valid) begin
                r_ghr                <= {r_ghr[1:0], resolve_taken};
                r_pht[resolve_index] <= sat_update(r_pht[resolve_index], resolve_taken);
            end
        end
    end

endmodule

// File: tb/tb_fetch_gshare_stage.sv
// Self-checking bench for fetch_gshare_stage: directed scenarios plus randomized
// traffic against an arithmetic reference model of PC, history and counters.
module tb_fetch_gshare_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Dstall = 1'b0;
    logic [15:0] imem_addr;
    logic [17:0] imem_data;
    logic [17:0] Finstruction;
    logic [15:0] Finstruction_increment;
    logic [15:0] Fpc;
    logic [2:0]  xorout;
    logic        Fpredict_taken;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [2:0]  resolve_index = 3'd0;
    logic        resolve_mispredict = 1'b0;
    logic [15:0] resolve_target = 16'h0000;
    logic        flush_FD;

    logic [17:0] mem [0:65535];
    int n_tests = 0;
    int n_fail = 0;

    int m_pc;
    int m_ghr;
    int m_pht [8];

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    fetch_gshare_stage #(
        .RESET_PC(16'h0010),
        .BRANCH_OPCODE(6'b010000),
        .JUMP_OPCODE(6'b010001)
    ) dut (
        .clk(clk), .reset(reset), .Dstall(Dstall),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .Finstruction(Finstruction), .Finstruction_increment(Finstruction_increment),
        .Fpc(Fpc), .xorout(xorout), .Fpredict_taken(Fpredict_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_index(resolve_index), .resolve_mispredict(resolve_mispredict),
        .resolve_target(resolve_target), .flush_FD(flush_FD)
    );

    // Reference model
    function automatic int exp_idx();
        return (m_pc % 8) ^ m_ghr;
    endfunction

    function automatic int exp_pred();
        int opc;
        opc = int'(mem[m_pc][17:12]);
        if (opc == 17) return 1;
        if (opc == 16 && m_pht[exp_idx()] >= 2) return 1;
        return 0;
    endfunction

    task automatic tick();
        int npc;
        if (reset) begin
            m_pc = 16;
            m_ghr = 0;
            for (int i = 0; i < 8; i++) m_pht[i] = 1;
        end else begin
            if (resolve_mispredict) npc = int'(resolve_target);
            else if (Dstall) npc = m_pc;
            else if (exp_pred() == 1) npc = (m_pc / 4096) * 4096 + int'(mem[m_pc][11:0]);
            else npc = (m_pc + 1) % 65536;
            if (resolve_valid) begin
                if (resolve_taken) m_pht[resolve_index] = (m_pht[resolve_index] == 3) ? 3 : m_pht[resolve_index] + 1;
                else m_pht[resolve_index] = (m_pht[resolve_index] == 0) ? 0 : m_pht[resolve_index] - 1;
                m_ghr = (m_ghr * 2 + (resolve_taken ? 1 : 0)) % 8;
            end
            m_pc = npc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Dstall = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
        resolve_index = 3'd0; resolve_mispredict = 1'b0; resolve_target = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] exp_pc;
        reset = 1'b1; idle_inputs();
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            exp_pc = 16'h0010 + 16'(k);
            n_tests++;
            if (Fpc !== exp_pc) begin n_fail++; $display("FAIL reset_fpc[%0d]: got %h want %h", k, Fpc, exp_pc); end
            n_tests++;
            if (xorout !== 3'(k)) begin n_fail++; $display("FAIL reset_xorout[%0d]: got %0d want %0d", k, xorout, k); end
            n_tests++;
            if (Fpredict_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred[%0d]: got %b want 0", k, Fpredict_taken); end
            if (k == 0) begin
                n_tests++;
                if (Finstruction_increment !== 16'h0011) begin n_fail++; $display("FAIL reset_inc: got %h want 0011", Finstruction_increment); end
                n_tests++;
                if (flush_FD !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_FD); end
            end
            tick();
        end
    endtask

    task automatic test_jump();
        resolve_mispredict = 1'b1; resolve_target = 16'h1005;
        #1;
        n_tests++;
        if (flush_FD !== 1'b1) begin n_fail++; $display("FAIL jump_redirect_flush: got %b want 1", flush_FD); end
        tick();
        resolve_mispredict = 1'b0;
        #1;
        n_tests++;
        if (Fpc !== 16'h1005) begin n_fail++; $display("FAIL jump_pc: got %h want 1005", Fpc); end
        n_tests++;
        if (Fpredict_taken !== 1'b1) begin n_fail++; $display("FAIL jump_pred: got %b want 1", Fpredict_taken); end
        n_tests++;
        if (Finstruction !== 18'b010001_000000100000) begin n_fail++; $display("FAIL jump_instr: got %h want %h", Finstruction, 18'b010001_000000100000); end
        tick();
        n_tests++;
        if (Fpc !== 16'h1020) begin n_fail++; $display("FAIL jump_target: got %h want 1020", Fpc); end
        n_tests++;
        if (xorout !== 3'd0) begin n_fail++; $display("FAIL jump_ghr_unchanged: got %0d want 0", xorout); end
    endtask

    task automatic test_gshare();
        Dstall = 1'b1; resolve_mispredict = 1'b1; resolve_target = 16'h0003;
        tick();
        resolve_mispredict = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_index = 3'd3;
        #1;
        n_tests++;
        if (xorout !== 3'd3 || Fpredict_taken !== 1'b0) begin n_fail++; $display("FAIL gshare_old_read: got idx %0d pred %b want idx 3 pred 0", xorout, Fpredict_taken); end
        tick();
        #1;
        n_tests++;
        if (xorout !== 3'd2) begin n_fail++; $display("FAIL gshare_ghr1: got %0d want 2", xorout); end
        tick();
        resolve_valid = 1'b0;
        #1;
        n_tests++;
        if (xorout !== 3'd0 || Fpredict_taken !== 1'b0) begin n_fail++; $display("FAIL gshare_ghr3_idx0: got idx %0d pred %b want idx 0 pred 0", xorout, Fpredict_taken); end
        n_tests++;
        if (Fpc !== 16'h0003) begin n_fail++; $display("FAIL gshare_stall_hold: got %h want 0003", Fpc); end
        resolve_mispredict = 1'b1; resolve_target = 16'h0000;
        tick();
        resolve_mispredict = 1'b0; Dstall = 1'b0;
        #1;
        n_tests++;
        if (xorout !== 3'd3 || Fpredict_taken !== 1'b1) begin n_fail++; $display("FAIL gshare_pht3_strong: got idx %0d pred %b want idx 3 pred 1", xorout, Fpredict_taken); end
        tick();
        n_tests++;
        if (Fpc !== 16'h0077) begin n_fail++; $display("FAIL gshare_taken_target: got %h want 0077", Fpc); end
    endtask

    task automatic test_mispredict_stall();
        Dstall = 1'b1; resolve_mispredict = 1'b1; resolve_target = 16'h0200;
        #1;
        n_tests++;
        if (flush_FD !== 1'b1) begin n_fail++; $display("FAIL mstall_flush: got %b want 1", flush_FD); end
        tick();
        resolve_mispredict = 1'b0;
        #1;
        n_tests++;
        if (Fpc !== 16'h0200 || flush_FD !== 1'b0) begin n_fail++; $display("FAIL mstall_pc: got %h flush %b want 0200 flush 0", Fpc, flush_FD); end
        tick(); tick();
        n_tests++;
        if (Fpc !== 16'h0200) begin n_fail++; $display("FAIL mstall_hold: got %h want 0200", Fpc); end
    endtask

    task automatic test_saturation();
        Dstall = 1'b1;
        resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_index = 3'd5;
        for (int k = 0; k < 5; k++) tick();
        resolve_valid = 1'b0;
        #1;
        n_tests++;
        if (xorout !== 3'd0) begin n_fail++; $display("FAIL sat_ghr_zero: got %0d want 0", xorout); end
        resolve_mispredict = 1'b1; resolve_target = 16'h0005;
        tick();
        resolve_mispredict = 1'b0;
        #1;
        n_tests++;
        if (xorout !== 3'd5 || Fpredict_taken !== 1'b0) begin n_fail++; $display("FAIL sat_pht5: got idx %0d pred %b want idx 5 pred 0", xorout, Fpredict_taken); end
        n_tests++;
        if (m_pht[5] != 0) begin n_fail++; $display("FAIL sat_model: got %0d want 0", m_pht[5]); end
    endtask

    task automatic test_wrap_and_reset();
        Dstall = 1'b1; resolve_mispredict = 1'b1; resolve_target = 16'hFFFF;
        tick();
        resolve_mispredict = 1'b0; Dstall = 1'b0;
        #1;
        n_tests++;
        if (Finstruction_increment !== 16'h0000) begin n_fail++; $display("FAIL wrap_inc: got %h want 0000", Finstruction_increment); end
        tick();
        n_tests++;
        if (Fpc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 0000", Fpc); end
        reset = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_index = 3'd3;
        tick();
        reset = 1'b0; resolve_valid = 1'b0;
        #1;
        n_tests++;
        if (Fpc !== 16'h0010 || xorout !== 3'd0) begin n_fail++; $display("FAIL midreset: got pc %h idx %0d want 0010 idx 0", Fpc, xorout); end
        Dstall = 1'b1; resolve_mispredict = 1'b1; resolve_target = 16'h0003;
        tick();
        resolve_mispredict = 1'b0;
        #1;
        n_tests++;
        if (xorout !== 3'd3 || Fpredict_taken !== 1'b0) begin n_fail++; $display("FAIL midreset_pht: got idx %0d pred %b want idx 3 pred 0", xorout, Fpredict_taken); end
        Dstall = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            Dstall = ($urandom_range(0, 3) == 0);
            resolve_valid = ($urandom_range(0, 1) == 1);
            resolve_taken = ($urandom_range(0, 1) == 1);
            resolve_index = 3'($urandom_range(0, 7));
            resolve_mispredict = ($urandom_range(0, 7) == 0);
            resolve_target = 16'($urandom_range(0, 65535));
            #1;
            n_tests++;
            if (Fpc !== 16'(m_pc) || imem_addr !== 16'(m_pc) || Finstruction_increment !== 16'((m_pc + 1) % 65536)) begin
                n_fail++; $display("FAIL rand_pc[%0d]: got %h/%h/%h want %h", c, Fpc, imem_addr, Finstruction_increment, 16'(m_pc));
            end
            n_tests++;
            if (xorout !== 3'(exp_idx()) || Fpredict_taken !== 1'(exp_pred())) begin
                n_fail++; $display("FAIL rand_pred[%0d]: got idx %0d pred %b want idx %0d pred %0d", c, xorout, Fpredict_taken, exp_idx(), exp_pred());
            end
            n_tests++;
            if (flush_FD !== resolve_mispredict || Finstruction !== mem[m_pc]) begin
                n_fail++; $display("FAIL rand_pass[%0d]: got flush %b instr %h want %b %h", c, flush_FD, Finstruction, resolve_mispredict, mem[m_pc]);
            end
            tick();
        end
        reset = 1'b0; idle_inputs();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            case ($urandom_range(0, 7))
                0, 1:    mem[a] = {6'b010000, 12'($urandom_range(0, 4095))};
                2:       mem[a] = {6'b010001, 12'($urandom_range(0, 4095))};
                default: mem[a] = {6'($urandom_range(18, 63)), 12'($urandom_range(0, 4095))};
            endcase
        end
        mem[16'h0010] = 18'h01234;
        mem[16'h0011] = 18'h05678;
        mem[16'h0012] = 18'h09ABC;
        mem[16'h1005] = 18'b010001_000000100000;
        mem[16'h0003] = {6'b010000, 12'h050};
        mem[16'h0000] = {6'b010000, 12'h077};
        mem[16'h0005] = {6'b010000, 12'h0AB};
        mem[16'hFFFF] = {6'b000011, 12'h123};
        for (int i = 0; i < 8; i++) m_pht[i] = 1;
        m_pc = 16; m_ghr = 0;

        test_reset();
        test_jump();
        test_gshare();
        test_mispredict_stall();
        test_saturation();
        test_wrap_and_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
